param_frame_generator: RTL and testbench
========================================

Name: param_frame_generator

Overview:
Parametrised successor to the fixed 16-byte frame generator. Captures a payload of 0..MAX_LEN bytes on a start request. Emits a byte stream SYNC, LEN, payload bytes, CRC-8 over a valid/ready handshake. Sits between the packet-assembly logic and the serialiser or link layer; backpressure comes from the downstream consumer.

Parameters:
MAX_LEN, 16, maximum payload bytes; legal range 1..255.
SYNC_BYTE, 8'hA5, first byte of every frame.
CRC_POLY, 8'h07, CRC-8 generator polynomial, MSB-first, implicit x^8.
CRC_INIT, 8'h00, CRC register value at start of each frame.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  frame request; accepted only when busy=0
len  in  8  payload length in bytes, sampled with an accepted start
payload_in  in  8*MAX_LEN  payload; byte i at bits [8i+7:8i]; sampled with an accepted start
frame_ready  in  1  downstream ready
frame_data  out  8  current output byte
frame_valid  out  1  frame_data is valid
frame_sof  out  1  high with the SYNC byte
frame_eof  out  1  high with the CRC byte
crc  out  8  CRC of the last completed frame; held until the next accepted start
busy  out  1  a frame is in progress (state != IDLE)
done  out  1  one-cycle pulse after the CRC byte transfers
len_err  out  1  one-cycle pulse when a start is rejected because len > MAX_LEN

Behaviour:
- Reset values: frame_data=0, frame_valid=0, frame_sof=0, frame_eof=0, crc=0, busy=0, done=0, len_err=0. State=IDLE. Payload regs and counter are don't-care.
- Reset takes priority in every state. A mid-frame reset aborts the frame with no done and no eof, and all outputs return to their reset values on the same edge.
- Transfer: a byte transfers on a clk edge where frame_valid && frame_ready.
- Stability: while frame_valid && !frame_ready, frame_data, frame_sof and frame_eof hold stable.
- frame_valid never drops before the byte transfers.
- FSM states: IDLE, SYNC, LEN, PAY, CRC.
  - IDLE: on start with len<=MAX_LEN, latch len and payload, set running CRC=CRC_INIT, go to SYNC.
  - SYNC: frame_valid=1 on the next cycle, so first-byte latency is 1 cycle after start. On transfer go to LEN.
  - LEN: frame_data=len. On transfer, fold len into the CRC. Go to PAY if len>0, else go to CRC.
  - PAY: byte index k runs 0..len-1, frame_data=payload[k], and each byte is folded into the CRC on transfer. After byte len-1, go to CRC.
  - CRC: frame_data=final CRC, frame_eof=1. On transfer, latch crc output, pulse done next cycle, go to IDLE.
- With frame_ready held high, a frame occupies len+3 consecutive valid cycles.
- In IDLE, start with len>MAX_LEN: no capture, stay in IDLE, len_err pulses next cycle. crc and busy are unchanged.
- start while busy=1 is ignored and is not queued.
- Minimum gap between frames: done cycle = IDLE. start in the done cycle is accepted, and its SYNC appears on the following cycle.
- CRC fold: crc ^= byte, then 8 iterations of crc = crc[7] ? (crc<<1)^CRC_POLY : crc<<1. The fold is combinational per byte, so there is no extra latency. SYNC_BYTE is excluded from the CRC.
- crc output changes only on an accepted start (cleared to CRC_INIT) or at CRC transfer.
- Payload bytes at index >= len are never emitted.

Test Plan:
1. len=1, payload[0]=8'h00, frame_ready=1 -> bytes A5, 01, 00, 15 on 4 consecutive cycles starting 1 cycle after start. sof on A5, eof on 15, done 1 cycle later, crc=8'h15.
2. len=0 -> bytes A5, 00, 00 (3 cycles). eof on the third byte, crc=8'h00, done pulse.
3. len=16, payload 01..10, frame_ready pattern 1,0,0,1,... -> 19 transfers in order 01..10 after A5, 10h. frame_data stable during every stall. Bench CRC model matches the crc output.
4. start with len=17 (MAX_LEN=16) -> len_err pulse, no frame_valid, busy stays 0. start while busy -> ignored, current frame unaffected.
5. reset asserted during PAY byte 5 of 16 -> next edge all outputs 0, no done. A new start then produces a full correct frame.
6. start asserted on the done cycle of a len=2 frame -> next SYNC appears 1 cycle later. crc is reinitialised and the second frame's CRC matches the model.

Source files
------------

// File: rtl/param_frame_generator.sv
// Frame generator: SYNC, LEN, 0..MAX_LEN payload bytes, then CRC-8 (SYNC excluded).
// Byte stream is presented over a valid/ready handshake with downstream backpressure.
module param_frame_generator #(
   parameter int          MAX_LEN   = 16,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter logic [7:0]  CRC_POLY  = 8'h07,
   parameter logic [7:0]  CRC_INIT  = 8'h00
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [7:0]             len,
   input  logic [8*MAX_LEN-1:0]   payload_in,
   input  logic                   frame_ready,
   output logic [7:0]             frame_data,
   output logic                   frame_valid,
   output logic                   frame_sof,
   output logic                   frame_eof,
   output logic [7:0]             crc,
   output logic                   busy,
   output logic                   done,
   output logic                   len_err
);

   localparam int         IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      LEN,
      PAY,
      CRC
   } state_t;

   state_t      state, state_next;
   logic [7:0]  len_r;
   logic [7:0]  idx;
   logic [7:0]  run_crc;
   logic [7:0]  pay_mem [MAX_LEN];
   logic        xfer;
   logic        accept;

   function automatic logic [7:0] crc_fold(input logic [7:0] c, input logic [7:0] b);
      logic [7:0] r;
      r = c ^ b;
      for (int unsigned i = 0; i < 8; i++) begin
         r = r[7] ? ((r << 1) ^ CRC_POLY) : (r << 1);
      end
      return r;
   endfunction

   assign xfer   = frame_valid && frame_ready;
   assign accept = (state == IDLE) && start && (len <= MAX_LEN8);

   always_comb begin
      state_next  = state;
      frame_data  = '0;
      frame_valid = 1'b0;
      frame_sof   = 1'b0;
      frame_eof   = 1'b0;
      busy        = (state != IDLE);
      case (state)
         IDLE: begin
            if (accept) state_next = SYNC;
         end
         SYNC: begin
            frame_data  = SYNC_BYTE;
            frame_valid = 1'b1;
            frame_sof   = 1'b1;
            if (xfer) state_next = LEN;
         end
         LEN: begin
            frame_data  = len_r;
            frame_valid = 1'b1;
            if (xfer) state_next = (len_r == 8'd0) ? CRC : PAY;
         end
         PAY: begin
            frame_data  = pay_mem[idx[IW-1:0]];
            frame_valid = 1'b1;
            if (xfer && (idx == len_r - 8'd1)) state_next = CRC;
         end
         CRC: begin
            frame_data  = run_crc;
            frame_valid = 1'b1;
            frame_eof   = 1'b1;
            if (xfer) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         len_r   <= '0;
         idx     <= '0;
         run_crc <= '0;
         crc     <= '0;
         done    <= 1'b0;
         len_err <= 1'b0;
      end else begin
         state   <= state_next;
         done    <= 1'b0;
         len_err <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  len_r   <= len;
                  idx     <= '0;
                  run_crc <= CRC_INIT;
                  crc     <= CRC_INIT;
               end else if (start) begin
                  len_err <= 1'b1;
               end
            end
            LEN: if (xfer) run_crc <= crc_fold(run_crc, len_r);
            PAY: begin
               if (xfer) begin
                  run_crc <= crc_fold(run_crc, pay_mem[idx[IW-1:0]]);
                  idx     <= idx + 8'd1;
               end
            end
            CRC: begin
               if (xfer) begin
                  crc  <= run_crc;
                  done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Payload storage has no reset; it is only read after a capture.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int unsigned i = 0; i < MAX_LEN; i++) begin
            pay_mem[i] <= payload_in[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_param_frame_generator.sv
// Scoreboard bench for param_frame_generator: directed frames, monitor checks every transfer.
module tb_param_frame_generator;

   localparam int ML = 16;

   logic              clk = 1'b0;
   logic              reset, start, frame_ready;
   logic [7:0]        len;
   logic [8*ML-1:0]   payload_in;
   logic [7:0]        frame_data, crc;
   logic              frame_valid, frame_sof, frame_eof, busy, done, len_err;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] d;
      logic       sof;
      logic       eof;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] crc_q[$];
   logic [7:0] pl [ML];
   logic [7:0] last_crc = 8'h00;
   bit         pending_done = 1'b0;
   logic [7:0] exp_crc_cur;

   param_frame_generator #(
      .MAX_LEN(ML),
      .SYNC_BYTE(8'hA5),
      .CRC_POLY(8'h07),
      .CRC_INIT(8'h00)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .len(len),
      .payload_in(payload_in),
      .frame_ready(frame_ready),
      .frame_data(frame_data),
      .frame_valid(frame_valid),
      .frame_sof(frame_sof),
      .frame_eof(frame_eof),
      .crc(crc),
      .busy(busy),
      .done(done),
      .len_err(len_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_fold(input logic [7:0] c, input logic [7:0] b);
      logic [7:0] r;
      r = c ^ b;
      for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pushes the expected frame for pl[0..n-1], pulses start, checks 1-cycle latency.
   task automatic send_start(input int n);
      exp_t       e;
      logic [7:0] c;
      e = '{8'hA5, 1'b1, 1'b0};
      exp_q.push_back(e);
      e = '{8'(n), 1'b0, 1'b0};
      exp_q.push_back(e);
      c = model_fold(8'h00, 8'(n));
      for (int i = 0; i < n; i++) begin
         e = '{pl[i], 1'b0, 1'b0};
         exp_q.push_back(e);
         c = model_fold(c, pl[i]);
      end
      e = '{c, 1'b0, 1'b1};
      exp_q.push_back(e);
      crc_q.push_back(c);
      last_crc = c;
      for (int i = 0; i < ML; i++) payload_in[8*i +: 8] = pl[i];
      len   = 8'(n);
      start = 1'b1;
      step();
      start = 1'b0;
      check("first_byte_valid", frame_valid, 1);
      check("first_byte_sof", frame_sof, 1);
      check("crc_reinit", crc, 8'h00);
   endtask

   // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating. Returns in the done cycle.
   task automatic run_until_done(input int mode, input int exp_valid);
      int cyc  = 0;
      int vcnt = 0;
      bit seen = 1'b0;
      while (!seen && cyc < 300) begin
         frame_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         if (frame_valid) vcnt++;
         step();
         cyc++;
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         errors++;
         checks++;
         $display("FAIL done_timeout: no done within 300 cycles");
      end
      if (exp_valid >= 0) check("valid_cycles", vcnt, exp_valid);
   endtask

   // Monitor: samples on the falling edge, pops the scoreboard on each transfer.
   initial begin
      exp_t       e;
      bit         stalled = 1'b0;
      logic [7:0] h_d;
      logic       h_sof, h_eof;
      forever begin
         @(negedge clk);
         if (reset) begin
            stalled      = 1'b0;
            pending_done = 1'b0;
         end else begin
            if (pending_done) begin
               check("done_pulse", done, 1);
               check("crc_out", crc, exp_crc_cur);
               pending_done = 1'b0;
            end else if (done) begin
               check("spurious_done", done, 0);
            end
            if (stalled) begin
               check("valid_hold", frame_valid, 1);
               if (frame_valid) begin
                  check("stall_data", frame_data, h_d);
                  check("stall_sof", frame_sof, h_sof);
                  check("stall_eof", frame_eof, h_eof);
               end
            end
            if (frame_valid && frame_ready) begin
               if (exp_q.size() == 0) begin
                  errors++;
                  checks++;
                  $display("FAIL unexpected_byte: got %0h with empty scoreboard", frame_data);
               end else begin
                  e = exp_q.pop_front();
                  check("byte_data", frame_data, e.d);
                  check("byte_sof", frame_sof, e.sof);
                  check("byte_eof", frame_eof, e.eof);
                  if (e.eof) begin
                     pending_done = 1'b1;
                     exp_crc_cur  = (crc_q.size() > 0) ? crc_q.pop_front() : 8'hXX;
                  end
               end
            end
            stalled = frame_valid && !frame_ready;
            h_d     = frame_data;
            h_sof   = frame_sof;
            h_eof   = frame_eof;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_data"}, frame_data, 0);
      check({tag, "_valid"}, frame_valid, 0);
      check({tag, "_sof"}, frame_sof, 0);
      check({tag, "_eof"}, frame_eof, 0);
      check({tag, "_crc"}, crc, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_len_err"}, len_err, 0);
   endtask

   initial begin
      reset       = 1'b1;
      start       = 1'b0;
      len         = '0;
      payload_in  = '0;
      frame_ready = 1'b1;
      for (int i = 0; i < ML; i++) pl[i] = 8'h00;
      step();
      step();
      check_all_zero("reset");
      reset = 1'b0;
      step();

      // 1: len=1, payload 00 -> A5 01 00 15
      pl[0] = 8'h00;
      send_start(1);
      run_until_done(0, 4);
      check("t1_crc_hand", crc, 8'h15);
      step();

      // 2: empty payload -> A5 00 00
      send_start(0);
      run_until_done(0, 3);
      check("t2_crc_hand", crc, 8'h00);
      step();

      // 3: full payload with ready pattern 1,0,0
      for (int i = 0; i < ML; i++) pl[i] = 8'(i + 1);
      send_start(16);
      run_until_done(1, -1);
      frame_ready = 1'b1;
      step();

      // 4a: oversize length is rejected
      len        = 8'd17;
      payload_in = '1;
      start      = 1'b1;
      step();
      start = 1'b0;
      check("t4_len_err", len_err, 1);
      check("t4_busy", busy, 0);
      check("t4_valid", frame_valid, 0);
      check("t4_crc_kept", crc, last_crc);
      step();
      check("t4_len_err_pulse", len_err, 0);

      // 4b: start while busy is ignored
      pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC; pl[3] = 8'hDD;
      send_start(4);
      step();
      len        = 8'd2;
      payload_in = '1;
      start      = 1'b1;
      step();
      start = 1'b0;
      run_until_done(0, -1);
      step();
      step();
      check("t4_no_requeue_busy", busy, 0);

      // 5: reset during payload byte 5 of 16
      for (int i = 0; i < ML; i++) pl[i] = 8'h30 + 8'(i);
      send_start(16);
      repeat (7) step();
      reset = 1'b1;
      step();
      check_all_zero("midreset");
      exp_q.delete();
      crc_q.delete();
      reset = 1'b0;
      step();
      check("t5_no_done", done, 0);
      send_start(16);
      run_until_done(0, 19);
      step();

      // 6: back-to-back start in the done cycle
      pl[0] = 8'h12; pl[1] = 8'h34;
      send_start(2);
      run_until_done(0, 5);
      pl[0] = 8'hFE; pl[1] = 8'h01; pl[2] = 8'h80;
      send_start(3);
      run_until_done(0, 6);
      repeat (3) step();

      check("scoreboard_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
